// File: rtl/lbdr_param_router_pkg.sv
// rtl/lbdr_param_router_pkg.sv - shared flit, port and turn-bit definitions for the LBDR router
package noc_pkg;

  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_idx_e;

  // {L,S,W,E,N}, indexed by port_idx_e
  typedef logic [4:0] port_onehot_t;

  // Bit positions inside Rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
  localparam int RNE = 0;
  localparam int RNW = 1;
  localparam int REN = 2;
  localparam int RES = 3;
  localparam int RWN = 4;
  localparam int RWS = 5;
  localparam int RSE = 6;
  localparam int RSW = 7;

  // Bit positions inside Cx = {Cs,Cw,Ce,Cn}
  localparam int CN = 0;
  localparam int CE = 1;
  localparam int CW = 2;
  localparam int CS = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } route_state_e;

endpackage

// File: rtl/lbdr_param_router_if.sv
// rtl/lbdr_param_router_if.sv - flit/allocator/config bundle between input port and router
interface lbdr_param_router_if #(
  parameter int ADDR_W = 4
) ();
  import noc_pkg::*;

  logic              flit_valid;
  logic [2:0]        flit_id;
  logic [ADDR_W-1:0] dst_addr;
  logic              flit_accept;
  logic              cfg_we;
  logic [7:0]        cfg_rxy;
  logic [3:0]        cfg_cx;
  logic [ADDR_W-1:0] cfg_cur;
  logic [2:0]        cfg_dr;
  port_onehot_t      port_req;
  logic              derouted;
  logic              drop;
  logic              route_err;
  logic              busy;

  modport master (
    output flit_valid, flit_id, dst_addr, flit_accept,
    output cfg_we, cfg_rxy, cfg_cx, cfg_cur, cfg_dr,
    input  port_req, derouted, drop, route_err, busy
  );

  modport slave (
    input  flit_valid, flit_id, dst_addr, flit_accept,
    input  cfg_we, cfg_rxy, cfg_cx, cfg_cur, cfg_dr,
    output port_req, derouted, drop, route_err, busy
  );

endinterface

// File: rtl/lbdr_param_router_route_fn.sv
// rtl/lbdr_param_router_route_fn.sv - combinational LBDR route function with deroute fallback
module lbdr_route_fn
  import noc_pkg::*;
#(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter bit DR_EN = 1'b1
) (
  input  logic [X_W+Y_W-1:0] cur_i,
  input  logic [X_W+Y_W-1:0] dst_i,
  input  logic [7:0]         rxy_i,
  input  logic [3:0]         cx_i,
  input  logic [2:0]         dr_i,
  output port_onehot_t       route_o,
  output logic               derouted_o
);

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic           n1, s1, e1, w1, l1;
  logic           req_n, req_e, req_w, req_s;

  assign x_cur = cur_i[X_W-1:0];
  assign x_dst = dst_i[X_W-1:0];
  assign y_cur = cur_i[X_W+Y_W-1:X_W];
  assign y_dst = dst_i[X_W+Y_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;
  assign l1 = ~n1 & ~e1 & ~w1 & ~s1;

  assign req_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_i[RNE]) | (n1 & w1 & rxy_i[RNW])) & cx_i[CN];
  assign req_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_i[REN]) | (e1 & s1 & rxy_i[RES])) & cx_i[CE];
  assign req_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_i[RWN]) | (w1 & s1 & rxy_i[RWS])) & cx_i[CW];
  assign req_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_i[RSE]) | (s1 & w1 & rxy_i[RSW])) & cx_i[CS];

  // Fixed N>E>W>S priority keeps the request one-hot when two minimal ports qualify
  always_comb begin
    route_o    = '0;
    derouted_o = 1'b0;
    if (l1) begin
      route_o[PORT_L] = 1'b1;
    end else if (req_n) begin
      route_o[PORT_N] = 1'b1;
    end else if (req_e) begin
      route_o[PORT_E] = 1'b1;
    end else if (req_w) begin
      route_o[PORT_W] = 1'b1;
    end else if (req_s) begin
      route_o[PORT_S] = 1'b1;
    end else if (DR_EN && dr_i[2] && cx_i[dr_i[1:0]]) begin
      route_o    = port_onehot_t'(5'b00001 << dr_i[1:0]);
      derouted_o = 1'b1;
    end
  end

endmodule

// File: rtl/lbdr_param_router.sv
// rtl/lbdr_param_router.sv - per-packet LBDR route FSM for one router input port
module lbdr_param_router
  import noc_pkg::*;
#(
  parameter int          X_W     = 2,
  parameter int          Y_W     = 2,
  parameter bit          DR_EN   = 1'b1,
  parameter logic [7:0]  RXY_DEF = 8'h3C,
  parameter logic [3:0]  CX_DEF  = 4'hF,
  parameter int          CUR_DEF = 5
) (
  input logic                clk,
  input logic                rst,
  lbdr_param_router_if.slave bus
);

  localparam int ADDR_W = X_W + Y_W;

  route_state_e      state_q, state_d;
  logic [7:0]        rxy_q;
  logic [3:0]        cx_q;
  logic [ADDR_W-1:0] cur_q;
  logic [2:0]        dr_q;
  port_onehot_t      port_req_q, port_req_d;
  logic              derouted_q, derouted_d;
  logic              route_err_q, route_err_d;
  logic              drop;

  port_onehot_t      route;
  logic              route_dr;
  logic              hdr_in;

  lbdr_route_fn #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .DR_EN (DR_EN)
  ) u_route_fn (
    .cur_i      (cur_q),
    .dst_i      (bus.dst_addr),
    .rxy_i      (rxy_q),
    .cx_i       (cx_q),
    .dr_i       (dr_q),
    .route_o    (route),
    .derouted_o (route_dr)
  );

  assign hdr_in = bus.flit_valid && (bus.flit_id == HEADER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_in) begin
          state_d = (route != '0) ? ST_ACTIVE : ST_DROP;
        end
      end
      ST_ACTIVE: begin
        if (bus.flit_accept && (bus.flit_id == TAIL)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (bus.flit_valid && (bus.flit_id == TAIL)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A config write clears the sticky error, but an error raised in the same cycle still lands
  always_comb begin
    port_req_d  = port_req_q;
    derouted_d  = derouted_q;
    route_err_d = bus.cfg_we ? 1'b0 : route_err_q;
    drop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_in) begin
          if (route != '0) begin
            port_req_d = route;
            derouted_d = route_dr;
          end else begin
            route_err_d = 1'b1;
          end
        end else if (bus.flit_valid) begin
          route_err_d = 1'b1;
          drop        = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (bus.flit_accept) begin
          if (bus.flit_id == TAIL) begin
            port_req_d = '0;
            derouted_d = 1'b0;
          end else if (bus.flit_id == HEADER) begin
            route_err_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        drop = bus.flit_valid;
      end
      default: begin
        port_req_d = '0;
        derouted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxy_q       <= RXY_DEF;
      cx_q        <= CX_DEF;
      cur_q       <= ADDR_W'(CUR_DEF);
      dr_q        <= 3'b000;
      port_req_q  <= '0;
      derouted_q  <= 1'b0;
      route_err_q <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        rxy_q <= bus.cfg_rxy;
        cx_q  <= bus.cfg_cx;
        cur_q <= bus.cfg_cur;
        dr_q  <= bus.cfg_dr;
      end
      port_req_q  <= port_req_d;
      derouted_q  <= derouted_d;
      route_err_q <= route_err_d;
    end
  end

  assign bus.port_req  = port_req_q;
  assign bus.derouted  = derouted_q;
  assign bus.drop      = drop;
  assign bus.route_err = route_err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/lbdr_param_router.md
Name: lbdr_param_router

Overview:
- Parametrised successor of the minimal LBDR routing unit for one router input port.
- Mesh coordinate widths are generic. Adds a deroute fallback, a per-packet route state machine (header latch, hold until tail) and explicit drop handling for unroutable packets.
- Sits between the input-port FIFO and the switch allocator. It issues one output-port request per packet and holds it until the tail flit is accepted.

Parameters:
- X_W, 2, width of the X coordinate field (address LSBs).
- Y_W, 2, width of the Y coordinate field (address MSBs); ADDR_W = X_W+Y_W.
- DR_EN, 1, enables the deroute fallback; when 0, cfg_dr is ignored.
- RXY_DEF, 8'h3C, routing bits loaded at reset.
- CX_DEF, 4'hF, connectivity bits loaded at reset.
- CUR_DEF, 5, router address loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flit_valid  in  1  FIFO holds a flit (not empty).
- flit_id  in  3  flit type (HEADER/BODY/TAIL from package).
- dst_addr  in  ADDR_W  destination of the current flit (meaningful on HEADER).
- flit_accept  in  1  allocator consumed the head flit this cycle.
- cfg_we  in  1  configuration write strobe.
- cfg_rxy  in  8  {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}.
- cfg_cx  in  4  {Cs,Cw,Ce,Cn}.
- cfg_cur  in  ADDR_W  this router's address.
- cfg_dr  in  3  {dr_valid, dr_port[1:0]}; port encoding is 0=N, 1=E, 2=W, 3=S.
- port_req  out  5  one-hot {L,S,W,E,N} route request.
- derouted  out  1  current route came from the deroute bits.
- drop  out  1  FIFO pop request while discarding an unroutable packet.
- route_err  out  1  sticky error flag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, async):
  - Rxy=RXY_DEF, Cx=CX_DEF, cur=CUR_DEF, dr=3'b000.
  - FSM=IDLE.
  - All outputs 0.
- Config:
  - cfg_we writes Rxy/Cx/cur/dr on the clock edge and clears route_err.
  - A new value affects only headers sampled after the write edge.
  - If cfg_we and a header arrive in the same cycle, the header uses the old config.
  - A route already latched is never altered by a config write.
- Route function (combinational, on the configuration registers):
  - N1=y_dst<y_cur, S1=y_cur<y_dst, E1=x_cur<x_dst, W1=x_dst<x_cur; comparisons are unsigned, width X_W/Y_W.
  - N=((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn.
  - E=((E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res))&Ce.
  - W=((W1&~N1&~S1)|(W1&N1&Rwn)|(W1&S1&Rws))&Cw.
  - S=((S1&~E1&~W1)|(S1&E1&Rse)|(S1&W1&Rsw))&Cs.
  - L=~N1&~E1&~W1&~S1 (connectivity not applied).
  - If both N and E (or similar) are set, the priority N>E>W>S keeps port_req one-hot.
  - If L=0, no minimal port is set, DR_EN=1, dr_valid=1 and C[dr_port]=1: select dr_port and flag deroute.
- FSM states: IDLE, ACTIVE, DROP.
  - IDLE: if flit_valid and flit_id==HEADER, compute the route.
    - Route non-empty: register port_req and derouted, go to ACTIVE. Latency is 1 cycle; the request is visible the cycle after the header is sampled.
    - Route empty: set route_err, go to DROP.
  - IDLE: a non-header valid flit sets route_err and asserts drop for that cycle (stray flit discarded).
  - ACTIVE: hold port_req/derouted stable.
    - On flit_accept with flit_id==TAIL: clear port_req/derouted at the next edge and go to IDLE.
    - A HEADER accepted in ACTIVE sets route_err; the route is unchanged.
  - DROP: drop=flit_valid (combinational).
    - When drop pops a TAIL, go to IDLE.
    - port_req stays 0 throughout.
- flit_accept while port_req==0 is ignored.
- A header may be routed in the cycle after the tail-to-IDLE transition; there is one bubble between packets.
- busy = (state != IDLE).

Decomposition:
- Package noc_pkg holds:
  - flit-id constants HEADER=3'b001, BODY=3'b010, TAIL=3'b100;
  - port index enum N/E/W/S/L;
  - typedef port_onehot_t (5 bits);
  - the Rxy bit-position constants.
- Sub-module lbdr_route_fn: purely combinational route function including the deroute select. It is instantiated once and reusable by the verification model.

Test Plan:
- After reset (cur=5, Rxy=8'h3C, Cx=4'hF), HEADER with dst=5 -> port_req=5'b10000 (L) one cycle later; busy=1. BODY then TAIL accepted -> port_req=0 and busy=0 after the tail edge.
- dst=1 -> N (5'b00001). dst=7 -> E (5'b00010). dst=0 -> W (5'b00100), because Rnw=0 and Rwn=1.
- cfg_cx=4'b1011, cfg_dr=3'b111, HEADER dst=0 -> minimal route empty, port_req=S (5'b01000), derouted=1.
- cfg_cx=4'b0000, dr_valid=0, 3-flit packet to dst=0 -> route_err=1, drop=1 for 3 valid cycles, then IDLE. A following cfg_we clears route_err.
- Reset pulse mid-packet in ACTIVE -> port_req=0 and state IDLE immediately (async). The config registers return to their parameter defaults.
- Packet in ACTIVE with cfg_we changing Cx -> port_req unchanged until the tail. The next header routes with the new Cx.
